// File: rtl/flow_pkg.sv
// Shared types and defaults for the optical-flow pyramid blocks.
package flow_pkg;

  localparam int unsigned FLOW_WIDTH_DEFAULT = 16;

  typedef enum logic [2:0] {
    StIdle,
    StReadCoarse,
    StWaitRead,
    StScale,
    StWriteBlock
  } state_t;

endpackage

// File: rtl/flow_scale_x2.sv
// Combinational doubling of one signed flow component.
// FLOW_UPSAMPLE_SAT_EN selects saturation; otherwise the result wraps.
module flow_scale_x2 import flow_pkg::*; #(
  parameter int unsigned FLOW_WIDTH = FLOW_WIDTH_DEFAULT
) (
  input  logic signed [FLOW_WIDTH-1:0] din_i,
  output logic signed [FLOW_WIDTH-1:0] dout_o
);

  always_comb begin
    dout_o = {din_i[FLOW_WIDTH-2:0], 1'b0};
`ifdef FLOW_UPSAMPLE_SAT_EN
    // Top two bits disagree: doubling leaves the representable range.
    if (din_i[FLOW_WIDTH-1] != din_i[FLOW_WIDTH-2]) begin
      dout_o = din_i[FLOW_WIDTH-1] ? {1'b1, {(FLOW_WIDTH-1){1'b0}}}
                                   : {1'b0, {(FLOW_WIDTH-1){1'b1}}};
    end
`endif
  end

endmodule

// File: rtl/flow_upsampler.sv
// Nearest-neighbour x2 flow upsampler: one coarse read feeds a 2x2 block of fine writes.
// Define FLOW_UPSAMPLE_SAT_EN to saturate the doubled flow instead of wrapping.
module flow_upsampler import flow_pkg::*; #(
  parameter int unsigned FLOW_WIDTH = FLOW_WIDTH_DEFAULT,
  parameter int unsigned WIDTH      = 160,
  parameter int unsigned HEIGHT     = 120,
  parameter int unsigned ADDR_WIDTH = 17
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         done,
  output logic                         busy,
  input  logic signed [FLOW_WIDTH-1:0] coarse_flow_u_data,
  input  logic signed [FLOW_WIDTH-1:0] coarse_flow_v_data,
  output logic        [ADDR_WIDTH-1:0] coarse_flow_addr,
  output logic                         coarse_flow_re,
  output logic signed [FLOW_WIDTH-1:0] fine_flow_u_data,
  output logic signed [FLOW_WIDTH-1:0] fine_flow_v_data,
  output logic        [ADDR_WIDTH-1:0] fine_flow_addr,
  output logic                         fine_flow_we
);

  localparam logic [ADDR_WIDTH-1:0] CxLast = ADDR_WIDTH'(WIDTH / 2 - 1);
  localparam logic [ADDR_WIDTH-1:0] CyLast = ADDR_WIDTH'(HEIGHT / 2 - 1);
  localparam logic [ADDR_WIDTH-1:0] FineW  = ADDR_WIDTH'(WIDTH);
  localparam logic [ADDR_WIDTH-1:0] Fine2W = ADDR_WIDTH'(2 * WIDTH);

  if ((WIDTH % 2) != 0 || (HEIGHT % 2) != 0) begin : g_dim_check
    $error("flow_upsampler: WIDTH and HEIGHT must both be even");
  end

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cx_q, cx_d, cy_q, cy_d;
  logic [ADDR_WIDTH-1:0]   caddr_q, caddr_d;
  logic [ADDR_WIDTH-1:0]   row_base_q, row_base_d;  // 2*cy*WIDTH, stepped per coarse row
  logic [1:0]              sub_q, sub_d;
  logic signed [FLOW_WIDTH-1:0] cu_q, cu_d, cv_q, cv_d;
  logic signed [FLOW_WIDTH-1:0] su_q, su_d, sv_q, sv_d;
  logic signed [FLOW_WIDTH-1:0] su_x2, sv_x2;
  logic [ADDR_WIDTH-1:0]   fine_col;
  logic                    last_px;

  flow_scale_x2 #(.FLOW_WIDTH(FLOW_WIDTH)) u_scale_u (.din_i(cu_q), .dout_o(su_x2));
  flow_scale_x2 #(.FLOW_WIDTH(FLOW_WIDTH)) u_scale_v (.din_i(cv_q), .dout_o(sv_x2));

  assign fine_col         = {cx_q[ADDR_WIDTH-2:0], 1'b0};
  assign last_px          = (cx_q == CxLast) && (cy_q == CyLast);
  assign busy             = (state_q != StIdle);
  assign coarse_flow_addr = caddr_q;
  assign fine_flow_u_data = su_q;
  assign fine_flow_v_data = sv_q;
  // sub_q[0] selects the right column, sub_q[1] the lower row of the 2x2 block.
  assign fine_flow_addr   = row_base_q + fine_col + ADDR_WIDTH'(sub_q[0])
                          + (sub_q[1] ? FineW : '0);

  always_comb begin
    state_d        = state_q;
    cx_d           = cx_q;
    cy_d           = cy_q;
    caddr_d        = caddr_q;
    row_base_d     = row_base_q;
    sub_d          = sub_q;
    cu_d           = cu_q;
    cv_d           = cv_q;
    su_d           = su_q;
    sv_d           = sv_q;
    coarse_flow_re = 1'b0;
    fine_flow_we   = 1'b0;
    done           = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StReadCoarse;
          cx_d       = '0;
          cy_d       = '0;
          caddr_d    = '0;
          row_base_d = '0;
          sub_d      = '0;
        end
      end
      StReadCoarse: begin
        coarse_flow_re = 1'b1;
        state_d        = StWaitRead;
      end
      StWaitRead: begin
        cu_d    = coarse_flow_u_data;
        cv_d    = coarse_flow_v_data;
        state_d = StScale;
      end
      StScale: begin
        su_d    = su_x2;
        sv_d    = sv_x2;
        state_d = StWriteBlock;
      end
      StWriteBlock: begin
        fine_flow_we = 1'b1;
        sub_d        = sub_q + 2'd1;
        if (sub_q == 2'd3) begin
          if (last_px) begin
            done    = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StReadCoarse;
            caddr_d = caddr_q + 1'b1;
            if (cx_q == CxLast) begin
              cx_d       = '0;
              cy_d       = cy_q + 1'b1;
              row_base_d = row_base_q + Fine2W;
            end else begin
              cx_d = cx_q + 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cx_q       <= '0;
      cy_q       <= '0;
      caddr_q    <= '0;
      row_base_q <= '0;
      sub_q      <= '0;
      cu_q       <= '0;
      cv_q       <= '0;
      su_q       <= '0;
      sv_q       <= '0;
    end else begin
      state_q    <= state_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      caddr_q    <= caddr_d;
      row_base_q <= row_base_d;
      sub_q      <= sub_d;
      cu_q       <= cu_d;
      cv_q       <= cv_d;
      su_q       <= su_d;
      sv_q       <= sv_d;
    end
  end

endmodule

// File: tb/tb_flow_upsampler.sv
// Directed bench for flow_upsampler: a 4x4 instance for data/timing cases and a
// default-size instance for the reset-abort and full-frame cases.
module tb_flow_upsampler;

  localparam int LW = 160;
  localparam int LH = 120;
  localparam int LN = LW * LH;
  localparam int LC = (LW / 2) * (LH / 2);

  logic clk, rst, start_s, start_l, clr;

  logic        done_s, busy_s, re_s, we_s;
  logic [16:0] caddr_s, faddr_s;
  logic [15:0] rdu_s, rdv_s, fu_o_s, fv_o_s;
  logic        done_l, busy_l, re_l, we_l;
  logic [16:0] caddr_l, faddr_l;
  logic [15:0] rdu_l, rdv_l, fu_o_l, fv_o_l;

  logic [15:0] cu_s [4];
  logic [15:0] cv_s [4];
  logic [15:0] cu_l [LC];
  logic [15:0] cv_l [LC];

  int          wcnt_s [16];
  logic [15:0] fu_s [16];
  logic [15:0] fv_s [16];
  int          wr_total_s, done_cnt_s;
  int          wcnt_l [LN];
  logic [15:0] fu_l [LN];
  logic [15:0] fv_l [LN];
  int          wr_total_l, done_cnt_l;

  int checks, errors;

  flow_upsampler #(.FLOW_WIDTH(16), .WIDTH(4), .HEIGHT(4), .ADDR_WIDTH(17)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .done(done_s), .busy(busy_s),
    .coarse_flow_u_data(rdu_s), .coarse_flow_v_data(rdv_s),
    .coarse_flow_addr(caddr_s), .coarse_flow_re(re_s),
    .fine_flow_u_data(fu_o_s), .fine_flow_v_data(fv_o_s),
    .fine_flow_addr(faddr_s), .fine_flow_we(we_s)
  );

  flow_upsampler dut_l (
    .clk(clk), .rst(rst), .start(start_l), .done(done_l), .busy(busy_l),
    .coarse_flow_u_data(rdu_l), .coarse_flow_v_data(rdv_l),
    .coarse_flow_addr(caddr_l), .coarse_flow_re(re_l),
    .fine_flow_u_data(fu_o_l), .fine_flow_v_data(fv_o_l),
    .fine_flow_addr(faddr_l), .fine_flow_we(we_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Coarse memories with one cycle of read latency.
  always @(posedge clk) begin
    if (re_s && caddr_s < 17'd4) begin
      rdu_s <= cu_s[caddr_s[1:0]];
      rdv_s <= cv_s[caddr_s[1:0]];
    end
    if (re_l && caddr_l < 17'(LC)) begin
      rdu_l <= cu_l[caddr_l];
      rdv_l <= cv_l[caddr_l];
    end
  end

  // Fine-memory monitors sample mid-cycle.
  always @(negedge clk) begin
    if (clr) begin
      for (int i = 0; i < 16; i++) wcnt_s[i] = 0;
      for (int i = 0; i < LN; i++) wcnt_l[i] = 0;
      wr_total_s = 0; done_cnt_s = 0; wr_total_l = 0; done_cnt_l = 0;
    end else begin
      if (we_s) begin
        wr_total_s++;
        if (faddr_s < 17'd16) begin
          wcnt_s[faddr_s[3:0]]++;
          fu_s[faddr_s[3:0]] = fu_o_s;
          fv_s[faddr_s[3:0]] = fv_o_s;
        end
      end
      if (done_s) done_cnt_s++;
      if (we_l) begin
        wr_total_l++;
        if (faddr_l < 17'(LN)) begin
          wcnt_l[faddr_l]++;
          fu_l[faddr_l] = fu_o_l;
          fv_l[faddr_l] = fv_o_l;
        end
      end
      if (done_l) done_cnt_l++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Start the 4x4 instance; optionally re-pulse start 10 cycles after accept.
  task automatic run_small(input bit repulse, output int cyc);
    int n;
    clear_mon();
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    n = 0;
    while (!done_s && n < 200) begin
      tick();
      n++;
      start_s = repulse && (n == 10);
    end
    start_s = 1'b0;
    cyc = n + 1;
  endtask

  task automatic small_summary(input string tag, input int cyc);
    int bad;
    check_eq({tag, "_cycles"}, cyc, 28);
    tick();
    check_eq({tag, "_busy_after"}, busy_s, 1'b0);
    check_eq({tag, "_done_after"}, done_s, 1'b0);
    tick();
    tick();
    check_eq({tag, "_writes"}, wr_total_s, 16);
    check_eq({tag, "_done_cnt"}, done_cnt_s, 1);
    bad = 0;
    for (int i = 0; i < 16; i++) if (wcnt_s[i] != 1) bad++;
    check_eq({tag, "_once"}, bad, 0);
  endtask

  logic [15:0] exp_u1 [16] = '{16'd2, 16'd2, 16'd4, 16'd4, 16'd2, 16'd2, 16'd4, 16'd4,
                               16'd6, 16'd6, 16'd8, 16'd8, 16'd6, 16'd6, 16'd8, 16'd8};
  logic [15:0] exp_v1 [16] = '{16'hFFFE, 16'hFFFE, 16'hFFFC, 16'hFFFC,
                               16'hFFFE, 16'hFFFE, 16'hFFFC, 16'hFFFC,
                               16'hFFFA, 16'hFFFA, 16'hFFF8, 16'hFFF8,
                               16'hFFFA, 16'hFFFA, 16'hFFF8, 16'hFFF8};
`ifdef FLOW_UPSAMPLE_SAT_EN
  logic [15:0] exp_u2 [4] = '{16'h7FFF, 16'h7FFE, 16'h8000, 16'h0002};
  logic [15:0] exp_v2 [4] = '{16'h8000, 16'hFFFA, 16'h8000, 16'h7FFF};
`else
  logic [15:0] exp_u2 [4] = '{16'hA000, 16'h7FFE, 16'h8000, 16'h0002};
  logic [15:0] exp_v2 [4] = '{16'h4000, 16'hFFFA, 16'h0000, 16'h8000};
`endif

  initial begin
    int cyc, n, bad_once, bad_u, bad_v, c;
    logic [15:0] eu, ev;
    checks = 0; errors = 0;
    rst = 1'b1; start_s = 1'b0; start_l = 1'b0; clr = 1'b0;
    for (int i = 0; i < LC; i++) begin
      cu_l[i] = 16'(i);
      cv_l[i] = 16'(0 - i);
    end
    repeat (3) tick();

    // Outputs while held in reset.
    check_eq("rst_busy", {busy_s, busy_l}, 2'b00);
    check_eq("rst_done", {done_s, done_l}, 2'b00);
    check_eq("rst_re_we", {re_s, we_s, re_l, we_l}, 4'b0000);
    check_eq("rst_addr", {caddr_s, faddr_s}, 34'd0);
    check_eq("rst_data", {fu_o_s, fv_o_s}, 32'd0);
    rst = 1'b0;
    tick();
    check_eq("idle_busy", busy_s, 1'b0);

    // Basic 4x4 pattern.
    cu_s = '{16'd1, 16'd2, 16'd3, 16'd4};
    cv_s = '{16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC};
    run_small(1'b0, cyc);
    small_summary("s1", cyc);
    for (int i = 0; i < 16; i++) begin
      check_eq($sformatf("s1_u[%0d]", i), fu_s[i], exp_u1[i]);
      check_eq($sformatf("s1_v[%0d]", i), fv_s[i], exp_v1[i]);
    end

    // Overflow boundaries, with a stray start mid-run.
    cu_s = '{16'h5000, 16'h3FFF, 16'hC000, 16'h0001};
    cv_s = '{16'hA000, 16'hFFFD, 16'h8000, 16'h4000};
    run_small(1'b1, cyc);
    small_summary("s2", cyc);
    for (int i = 0; i < 16; i++) begin
      c = ((i / 4) / 2) * 2 + (i % 4) / 2;
      check_eq($sformatf("s2_u[%0d]", i), fu_s[i], exp_u2[c]);
      check_eq($sformatf("s2_v[%0d]", i), fv_s[i], exp_v2[c]);
    end

    // Reset during the 2x2 write block of coarse pixel 5.
    clear_mon();
    start_l = 1'b1;
    tick();
    start_l = 1'b0;
    n = 0;
    while (wr_total_l < 21 && n < 500) begin
      tick();
      n++;
    end
    check_eq("l_we_before_rst", we_l, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("l_rst_we", we_l, 1'b0);
    check_eq("l_rst_busy_re_done", {busy_l, re_l, done_l}, 3'b000);
    check_eq("l_rst_faddr", faddr_l, 17'd0);
    tick();
    rst = 1'b0;
    repeat (5) tick();
    check_eq("l_abort_writes", wr_total_l, 21);

    // Full default-size frame after the abort.
    clear_mon();
    start_l = 1'b1;
    tick();
    start_l = 1'b0;
    check_eq("l_first_re", re_l, 1'b1);
    check_eq("l_first_addr", caddr_l, 17'd0);
    n = 0;
    while (!done_l && n < 40000) begin
      tick();
      n++;
    end
    check_eq("l_cycles", n + 1, 33600);
    tick();
    check_eq("l_busy_after", busy_l, 1'b0);
    tick();
    tick();
    check_eq("l_writes", wr_total_l, LN);
    check_eq("l_done_cnt", done_cnt_l, 1);
    bad_once = 0; bad_u = 0; bad_v = 0;
    for (int y = 0; y < LH; y++) begin
      for (int x = 0; x < LW; x++) begin
        c  = (y / 2) * (LW / 2) + x / 2;
        eu = 16'(2 * c);
        ev = 16'(0 - 2 * c);
        if (wcnt_l[y * LW + x] != 1) bad_once++;
        else begin
          if (fu_l[y * LW + x] !== eu) bad_u++;
          if (fv_l[y * LW + x] !== ev) bad_v++;
        end
      end
    end
    check_eq("l_once", bad_once, 0);
    check_eq("l_data_u", bad_u, 0);
    check_eq("l_data_v", bad_v, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flow_upsampler.md
FLOW_UPSAMPLER -- requirements
Module: flow_upsampler

Interface
REQ-001 SHALL have parameter FLOW_WIDTH, default 16, signed flow component width.
REQ-002 SHALL have parameter WIDTH, default 160, fine (output) level width in pixels.
REQ-003 SHALL have parameter HEIGHT, default 120, fine level height in pixels.
REQ-004 SHALL have parameter ADDR_WIDTH, default 17, flow memory address width.
REQ-005 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port start  in  1  single-cycle request to upsample one level.
REQ-008 SHALL have port done  out  1  one-cycle completion pulse.
REQ-009 SHALL have port busy  out  1  high from the accepted start until done.
REQ-010 SHALL have ports coarse_flow_u_data / coarse_flow_v_data  in  FLOW_WIDTH signed  coarse flow read data.
REQ-011 SHALL have ports coarse_flow_addr  out  ADDR_WIDTH and coarse_flow_re  out  1  coarse read request.
REQ-012 SHALL have ports fine_flow_u_data / fine_flow_v_data  out  FLOW_WIDTH signed  upsampled write data.
REQ-013 SHALL have ports fine_flow_addr  out  ADDR_WIDTH and fine_flow_we  out  1  fine write strobe.

Function
REQ-014 Coarse grid SHALL be (WIDTH/2) x (HEIGHT/2), raster order, addr = cy*(WIDTH/2)+cx; fine addr = y*WIDTH+x.
REQ-015 Every fine pixel (x,y) SHALL receive 2*coarse(x>>1, y>>1) for both u and v (nearest neighbour, magnitude doubled).
REQ-016 FSM states SHALL be IDLE, READ_COARSE, WAIT_READ, SCALE, WRITE_BLOCK.
REQ-017 IDLE: start=1 -> READ_COARSE, coarse counters cleared, busy=1; start while not IDLE SHALL be ignored.
REQ-018 READ_COARSE: register coarse_flow_addr and coarse_flow_re=1 for one cycle -> WAIT_READ.
REQ-019 WAIT_READ: capture coarse data (1-cycle memory latency) -> SCALE.
REQ-020 SCALE: compute doubled u and v into registers -> WRITE_BLOCK.
REQ-021 WRITE_BLOCK: four consecutive cycles with fine_flow_we=1, addresses (2cx,2cy), (2cx+1,2cy), (2cx,2cy+1), (2cx+1,2cy+1), same data each cycle.
REQ-022 After 4th write: if last coarse pixel -> IDLE, done=1 coincident with that write, busy=0 next cycle; else advance cx (wrap to 0 and increment cy at WIDTH/2-1) -> READ_COARSE.
REQ-023 Per coarse pixel cost SHALL be exactly 7 cycles; start-accept to done SHALL be 7*(WIDTH/2)*(HEIGHT/2) cycles.
REQ-024 Fine addresses SHALL be generated from incremental row/column counters, no runtime multiplier.
REQ-025 coarse_flow_re, fine_flow_we, done SHALL default to 0 every cycle unless asserted by the current state.
REQ-026 WIDTH and HEIGHT not both even SHALL raise an elaboration-time error.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, counters 0, done/busy/coarse_flow_re/fine_flow_we 0, all addr/data outputs 0.
REQ-028 Reset mid-operation SHALL abort with no further writes; next start restarts from coarse pixel 0.

Configuration
REQ-029 With FLOW_UPSAMPLE_SAT_EN defined, doubling SHALL saturate to [-2^(FLOW_WIDTH-1), 2^(FLOW_WIDTH-1)-1].
REQ-030 Without FLOW_UPSAMPLE_SAT_EN, doubling SHALL be a plain left shift by 1, discarding overflow (two's-complement wrap).

Structure
REQ-031 Shared package flow_pkg SHALL hold the upsampler state_t typedef and the FLOW_WIDTH default constant.
REQ-032 One sub-module flow_scale_x2 (combinational doubling with optional saturation) SHALL be instantiated per component.

Verification
REQ-033 WIDTH=4, HEIGHT=4, coarse u={1,2,3,4}, v={-1,-2,-3,-4} -> fine u row0 {2,2,4,4}, row3 {6,6,8,8}; v negated; 16 writes, done after 28 cycles.
REQ-034 Coarse u=16'sh5000 -> fine 16'sh7FFF with FLOW_UPSAMPLE_SAT_EN, 16'shA000 without.
REQ-035 Coarse v=-16'sh6000 -> fine 16'sh8000 with macro; v=-3 -> -6 in both builds.
REQ-036 start pulsed again 10 cycles after accept -> ignored; single done; write count exactly WIDTH*HEIGHT.
REQ-037 rst asserted during WRITE_BLOCK of pixel 5 -> fine_flow_we 0 same cycle; new start -> first read at coarse addr 0.
REQ-038 Default parameters -> done exactly 33600 cycles after start accept; every fine address 0..19199 written once.
